decoder_scan_seq: RTL and testbench
===================================

# decoder_scan_seq

Registered channel sequencer that drives the 2-bit select (x1:x0) of the two2four decoder stage directly downstream. It walks four request lines in round-robin order and holds each selected channel for a programmable dwell time, or less if the consumer signals completion early. It gives the decoder a glitch-free, register-driven select and a busy flag the rest of the datapath can qualify on.

## Interface
- DWELL, 4, maximum cycles a channel stays selected; legal 1..255
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  scan enable; low freezes state, counter and outputs
- r0  input  1  request, channel 0
- r1  input  1  request, channel 1
- r2  input  1  request, channel 2
- r3  input  1  request, channel 3
- done  input  1  consumer finished the current channel; ends the hold early
- x0  output  1  select LSB to decoder (registered)
- x1  output  1  select MSB to decoder (registered)
- busy  output  1  high while a channel is held (registered)

## Operation
- Reset values: x0=0, x1=0, busy=0, state=IDLE, dwell counter=0, last-served pointer=3, so the first search starts at channel 0.
- States:
  - IDLE: busy=0; x holds its last value. If en and any request is set, go to HOLD with x = next channel.
  - HOLD: busy=1; the counter increments each enabled cycle.
- Leaving HOLD: the hold ends when the counter reaches DWELL-1 or done=1, whichever comes first.
  - At that point the pointer is updated to the current channel.
  - The next channel is searched round-robin from pointer+1, wrapping 3→0, using the request values sampled in that cycle.
  - If a channel is found: stay in HOLD, load x with it, clear the counter.
  - If none is found: go to IDLE, clear busy, keep x.
- The current channel is eligible again only after the other three have been checked. If it is the sole requester, it is re-selected and the counter restarts.
- done while in IDLE is ignored.
- A request that drops mid-hold does not end the hold. Only the dwell count or done ends it.
- en low stalls the block: nothing changes, and done and the requests are not sampled.
- rst asserted mid-hold returns every register to its reset value immediately. The first grant after release is channel 0 if r0 is set.
- Counter: 8-bit unsigned. The compare is against DWELL-1, so with DWELL=1 every enabled HOLD cycle is a hand-off. The counter never wraps.

## Timing
- Select latency: 1 clk from the sampled request (IDLE→HOLD) or from the hold-end condition to new x on the next edge.
- x0, x1 and busy change only on a clk edge or asynchronously on rst. The decoder outputs therefore settle one decoder delay after the edge.
- Hold length with no done: exactly DWELL enabled cycles per channel.
- done sampled at edge N: the new select is visible after edge N. The counter value at that point is irrelevant.
- done and counter = DWELL-1 in the same cycle: treated as a single hand-off with no extra cycle.

## Configuration
- SCAN_SKIP_EN defined: round-robin skips channels whose request is low (behaviour described above).
- SCAN_SKIP_EN undefined: pure sequential scan.
  - Once any request starts the scan, x steps 0→1→2→3→0 regardless of individual requests.
  - Every channel is held for DWELL cycles, or until done.
  - The block returns to IDLE only when all requests are low at a hand-off.
  - busy behaves the same as with the macro defined.

## Test plan
- Reset, then r0..r3=0 with en=1 for 10 cycles → x1:x0=00, busy=0 throughout.
- DWELL=4, r0=r2=1, SCAN_SKIP_EN defined → x sequence 00 (4 cycles), 10 (4 cycles), 00, …; busy=1 from the cycle after the requests appear.
- DWELL=4, r1=1 only, done pulsed on the 2nd hold cycle → x=01 re-selected with the counter restarted; the hold lasts 2 cycles, then 4.
- en=0 for 3 cycles during a hold of channel 3 → x=11 and the counter are frozen, and the remaining dwell resumes after en returns to 1.
- rst pulsed in the middle of a channel-2 hold with r0..r3=1 → x=00 and busy=0 immediately; after release x=00 (channel 0) on the first edge.
- SCAN_SKIP_EN undefined, DWELL=2, r3=1 only → x steps 00,01,10,11 for 2 cycles each, then goes to IDLE if r3 drops before the hand-off from 11.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
// Registered channel sequencer that drives the 2-bit select (x1:x0) of the
// downstream two2four decoder. Walks four request lines round-robin and holds
// each selected channel for up to DWELL enabled cycles, or less when the
// consumer raises done.
//
// Build option: define SCAN_SKIP_EN to skip channels whose request is low.
// Without it the scan steps 0->1->2->3->0 unconditionally while any request
// is pending.
module decoder_scan_seq #(
  parameter int unsigned DWELL = 4  // legal 1..255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  input  logic done,
  output logic x0,
  output logic x1,
  output logic busy
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_HOLD  = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  logic       state;
  logic [7:0] cnt;
  logic [1:0] ptr;       // last channel served
  logic [1:0] sel;       // registered select driven to the decoder
  logic [3:0] req;
  logic [1:0] base;      // channel the round-robin search starts after
  logic       found;
  logic [1:0] next_ch;
  logic       hand_off;

  assign req = {r3, r2, r1, r0};

  // At a hand-off the pointer becomes the current channel, so the search
  // starts after sel; from IDLE it starts after the last-served pointer.
  assign base     = (state == ST_HOLD) ? sel : ptr;
  assign hand_off = (state == ST_HOLD) && ((cnt == CNT_LAST) || done);

`ifdef SCAN_SKIP_EN
  // Round-robin search over requesting channels; the current channel is
  // visited last (offset 4 wraps back to base).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    found   = 1'b0;
    next_ch = base;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[base + 2'(i)]) begin
        found   = 1'b1;
        next_ch = base + 2'(i);
      end
    end
  end
`else
  // Pure sequential scan: always advance by one while anything is requesting.
  always_comb begin
    found   = |req;
    next_ch = base + 2'd1;
  end
`endif

  // Sequencer state, dwell counter, pointer and registered outputs.
  // NOTE: all state uses non-blocking assignments and is cleared
  // asynchronously so the decoder select is defined the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      ptr   <= 2'd3;
      sel   <= 2'd0;
      busy  <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_HOLD;
            sel   <= next_ch;
            cnt   <= 8'd0;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (hand_off) begin
            ptr <= sel;
            cnt <= 8'd0;
            if (found) begin
              sel <= next_ch;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign x0 = sel[0];
  assign x1 = sel[1];

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Testbench for decoder_scan_seq (DWELL=4). Stimulus pushes the expected
// {x1x0, busy} for each clock edge into a queue; a monitor pops and compares
// after every rising edge. Mode-specific expectations follow SCAN_SKIP_EN.
module tb_decoder_scan_seq;

  typedef struct {
    string      name;
    logic [1:0] x;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic done = 1'b0;
  logic x0, x1, busy;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decoder_scan_seq #(.DWELL(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .r0   (r0),
    .r1   (r1),
    .r2   (r2),
    .r3   (r3),
    .done (done),
    .x0   (x0),
    .x1   (x1),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: x1x0,busy got %b required %b", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the expectation applies after the next rising edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [3:0] r_v,
                      input logic done_v, input logic [1:0] ex, input logic eb,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst  = rst_v;
    en   = en_v;
    {r3, r2, r1, r0} = r_v;
    done = done_v;
    e.name = nm;
    e.x    = ex;
    e.busy = eb;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n, input logic en_v, input logic [3:0] r_v,
                       input logic done_v, input logic [1:0] ex, input logic eb,
                       input string nm);
    for (int i = 0; i < n; i++)
      step(1'b0, en_v, r_v, done_v, ex, eb, $sformatf("%s[%0d]", nm, i));
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, nm);
  endtask

  // Monitor: compare outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {x1, x0, busy}, {e.x, e.busy});
      end
    end
  end

  initial begin
    // Power-on reset and idle with no requests.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, "por0");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, "por1");
    steps(10, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, "idle");

    // Scenario A: r0 and r2 requesting, full dwell of 4 per channel.
    do_reset("rstA");
    steps(4, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b1, "A_ch0");
`ifdef SCAN_SKIP_EN
    steps(4, 1'b1, 4'b0101, 1'b0, 2'd2, 1'b1, "A_ch2");
    steps(4, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b1, "A_ch0b");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, "A_idle");
`else
    steps(4, 1'b1, 4'b0101, 1'b0, 2'd1, 1'b1, "A_ch1");
    steps(4, 1'b1, 4'b0101, 1'b0, 2'd2, 1'b1, "A_ch2");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, "A_idle");
`endif

    // Scenario B: r1 only, done on the 2nd hold cycle restarts the dwell.
    do_reset("rstB");
`ifdef SCAN_SKIP_EN
    steps(2, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, "B_first");
`else
    steps(2, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, "B_first");
`endif
    step(1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, "B_done");
    steps(2, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, "B_hold");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, "B_drop");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, "B_end");
    step(1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, "B_idle_done");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, "B_idle");

    // Scenario C: en low in IDLE, then freeze mid-hold of channel 3.
    do_reset("rstC");
    steps(2, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, "C_en0_idle");
`ifndef SCAN_SKIP_EN
    steps(4, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1, "C_ch0");
    steps(4, 1'b1, 4'b1000, 1'b0, 2'd1, 1'b1, "C_ch1");
    steps(4, 1'b1, 4'b1000, 1'b0, 2'd2, 1'b1, "C_ch2");
`endif
    steps(2, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, "C_ch3");
    steps(3, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, "C_frozen");
    steps(2, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, "C_resume");
    step(1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, "C_end");

    // Scenario D: reset in the middle of a channel-2 hold, all requesting.
    do_reset("rstD");
    steps(4, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, "D_ch0");
    steps(4, 1'b1, 4'b1111, 1'b0, 2'd1, 1'b1, "D_ch1");
    steps(2, 1'b1, 4'b1111, 1'b0, 2'd2, 1'b1, "D_ch2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("D_rst_async", {x1, x0, busy}, 3'b000);
    step(1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, "D_in_rst");
    step(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, "D_release");
    step(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, "D_hold");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
